// File: rtl/ht_task_dispatcher_pkg.sv
// ht_task_dispatcher_pkg: hash-table task types and dispatcher state encoding.
package ht_task_dispatcher_pkg;
  typedef enum logic [2:0] {
    OP_SEARCH = 3'd0,
    OP_INSERT = 3'd1,
    OP_DELETE = 3'd2
  } ht_opcode_e;
  typedef struct packed {
    ht_opcode_e  opcode;
    logic [31:0] key;
    logic [31:0] value;
  } ht_cmd_t;
  typedef struct packed {
    ht_cmd_t     cmd;
    logic [7:0]  bucket;
    logic [7:0]  head_ptr;
    logic        head_ptr_val;
  } ht_pdata_t;
  typedef enum logic [2:0] {
    IDLE_S,
    DRAIN_S,
    SEND_S,
    EXCL_S,
    BAD_S
  } ht_disp_state_t;
endpackage

// File: rtl/ht_outstanding_cnt.sv
// ht_outstanding_cnt: up/down counter that saturates at zero on decrement and wraps on increment.
module ht_outstanding_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic [W-1:0] next_cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = clr ? '0 :
            (inc && !dec) ? cnt_q + W'(1) :
            (dec && !inc && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign cnt      = cnt_q;
  assign next_cnt = cnt_d;
endmodule

// File: rtl/ht_task_dispatcher.sv
// ht_task_dispatcher: routes head-table tasks to search/insert/delete engines, overlapping searches
// and serialising inserts/deletes. Optional statistics counters under HT_DISPATCH_STATS_EN.
module ht_task_dispatcher
  import ht_task_dispatcher_pkg::*;
#(
  parameter int MAX_SEARCH = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  ht_pdata_t   task_i,
  input  logic        task_valid_i,
  output logic        task_ready_o,
  output ht_pdata_t   search_task_o,
  output ht_pdata_t   insert_task_o,
  output ht_pdata_t   delete_task_o,
  output logic        search_valid_o,
  output logic        insert_valid_o,
  output logic        delete_valid_o,
  input  logic        search_ready_i,
  input  logic        insert_ready_i,
  input  logic        delete_ready_i,
  input  logic        search_done_i,
  input  logic        insert_done_i,
  input  logic        delete_done_i,
`ifdef HT_DISPATCH_STATS_EN
  input  logic        stat_clr_i,
  output logic [31:0] stat_search_o,
  output logic [31:0] stat_insert_o,
  output logic [31:0] stat_delete_o,
  output logic [31:0] stat_stall_o,
`endif
  output logic        busy_o,
  output logic        bad_opcode_o
);
  ht_disp_state_t state_q, state_d;
  ht_pdata_t      task_locked_q, task_locked_d;
  logic [CNT_W-1:0] search_cnt, search_next;
  logic search_hs, insert_hs, delete_hs, excl_done;
  ht_opcode_e lock_op, in_op;
  assign lock_op   = task_locked_q.cmd.opcode;
  assign in_op     = task_i.cmd.opcode;
  assign search_valid_o = state_q == SEND_S && lock_op == OP_SEARCH && search_cnt < CNT_W'(MAX_SEARCH);
  assign insert_valid_o = state_q == SEND_S && lock_op == OP_INSERT;
  assign delete_valid_o = state_q == SEND_S && lock_op == OP_DELETE;
  assign search_hs = search_valid_o && search_ready_i;
  assign insert_hs = insert_valid_o && insert_ready_i;
  assign delete_hs = delete_valid_o && delete_ready_i;
  assign excl_done = (lock_op == OP_INSERT && insert_done_i) || (lock_op == OP_DELETE && delete_done_i);
  assign task_ready_o  = state_q == IDLE_S;
  assign bad_opcode_o  = state_q == BAD_S;
  assign busy_o        = state_q != IDLE_S || search_cnt != '0;
  assign search_task_o = task_locked_q;
  assign insert_task_o = task_locked_q;
  assign delete_task_o = task_locked_q;
  ht_outstanding_cnt #(.W(CNT_W)) u_search_cnt (
    .clk(clk_i), .rst(rst_i), .clr(1'b0), .inc(search_hs), .dec(search_done_i),
    .cnt(search_cnt), .next_cnt(search_next)
  );
  always_comb begin
    state_d       = state_q;
    task_locked_d = task_locked_q;
    case (state_q)
      IDLE_S: if (task_valid_i) begin
        task_locked_d = task_i;
        state_d = in_op == OP_SEARCH ? SEND_S :
                  (in_op == OP_INSERT || in_op == OP_DELETE) ? (search_next == '0 ? SEND_S : DRAIN_S) :
                  BAD_S;
      end
      DRAIN_S: state_d = search_next == '0 ? SEND_S : DRAIN_S;
      SEND_S:  state_d = search_hs ? IDLE_S : (insert_hs || delete_hs) ? EXCL_S : SEND_S;
      EXCL_S:  state_d = excl_done ? IDLE_S : EXCL_S;
      default: state_d = IDLE_S;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q       <= IDLE_S;
      task_locked_q <= '0;
    end else begin
      state_q       <= state_d;
      task_locked_q <= task_locked_d;
    end
`ifdef HT_DISPATCH_STATS_EN
  logic stall;
  logic [31:0] nxt_s, nxt_i, nxt_d, nxt_t;
  // A stall is any cycle a held task could not be offered to its engine.
  assign stall = state_q == DRAIN_S ||
                 (state_q == SEND_S && !(search_valid_o || insert_valid_o || delete_valid_o));
  ht_outstanding_cnt #(.W(32)) u_stat_s (.clk(clk_i), .rst(rst_i), .clr(stat_clr_i), .inc(search_hs),
    .dec(1'b0), .cnt(stat_search_o), .next_cnt(nxt_s));
  ht_outstanding_cnt #(.W(32)) u_stat_i (.clk(clk_i), .rst(rst_i), .clr(stat_clr_i), .inc(insert_hs),
    .dec(1'b0), .cnt(stat_insert_o), .next_cnt(nxt_i));
  ht_outstanding_cnt #(.W(32)) u_stat_d (.clk(clk_i), .rst(rst_i), .clr(stat_clr_i), .inc(delete_hs),
    .dec(1'b0), .cnt(stat_delete_o), .next_cnt(nxt_d));
  ht_outstanding_cnt #(.W(32)) u_stat_t (.clk(clk_i), .rst(rst_i), .clr(stat_clr_i), .inc(stall),
    .dec(1'b0), .cnt(stat_stall_o), .next_cnt(nxt_t));
`endif
endmodule
